// File: rtl/panel_pkg.sv
// Shared panel definitions: sequencer states, driver command codes, arbitration helper.
// The panel PWM driver uses the same CMD_* encodings.
package panel_pkg;

    localparam logic [1:0] CMD_STOP    = 2'b00;
    localparam logic [1:0] CMD_EXTEND  = 2'b01;
    localparam logic [1:0] CMD_RETRACT = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXTEND,
        S_HOLD,
        S_ABGAP,
        S_RETRACT,
        S_DONE
    } state_t;

    function automatic logic [1:0] state_cmd(state_t s);
        case (s)
            S_EXTEND:  return CMD_EXTEND;
            S_RETRACT: return CMD_RETRACT;
            default:   return CMD_STOP;
        endcase
    endfunction

    // Strategy requester (bit 0) beats manual requester (bit 1).
    function automatic logic [1:0] fixed_pri(logic [1:0] r);
        if (r[0])      return 2'b01;
        else if (r[1]) return 2'b10;
        else           return 2'b00;
    endfunction

endpackage

// File: rtl/panel_sequencer_if.sv
// Request/grant/command bundle between the panel requesters and the sequencer.
// master = requester side, slave = sequencer side.
interface panel_sequencer_if;
    logic [1:0] req;
    logic       abort;
    logic [1:0] gnt;
    logic [1:0] ack;
    logic       aborted;
    logic       busy;
    logic [1:0] command;

    modport master (output req, abort, input gnt, ack, aborted, busy, command);
    modport slave  (input req, abort, output gnt, ack, aborted, busy, command);
endinterface

// File: rtl/phase_timer.sv
// Phase down-counter: load sets the count, it decrements to 0 and holds; expire is count==0.
// Latency: loaded value visible the cycle after load; no backpressure.
module phase_timer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)              count <= '0;
        else if (load)          count <= load_val;
        else if (count != '0)   count <= count - CNT_W'(1);
    end

    assign expire = (count == '0);

endmodule

// File: rtl/panel_sequencer.sv
// Panel servo sequencer: extend -> hold -> retract for one of two requesters, with abort.
// Latency: grant and first EXTEND command one cycle after req; all outputs registered; no backpressure.
// Build option PANEL_SEQ_ROUND_ROBIN_EN: round-robin arbitration instead of fixed priority.
module panel_sequencer
    import panel_pkg::*;
#(
    parameter int T_EXT  = 40_000_000,
    parameter int T_HOLD = 50_000_000,
    parameter int T_RET  = 40_000_000,
    parameter int CNT_W  = 32
) (
    input  logic               clk,
    input  logic               reset,
    panel_sequencer_if.slave   bus
);

    state_t     state, state_nxt;
    logic [1:0] gnt, gnt_nxt;
    logic [1:0] ack, ack_nxt;
    logic       aborted, aborted_nxt;
    logic       abort_seen, abort_seen_nxt;
    logic       busy;
    logic [1:0] command;
    logic [1:0] win;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             expire;

`ifdef PANEL_SEQ_ROUND_ROBIN_EN
    logic ptr;  // last owner: 0 = strategy, 1 = manual

    always_comb win = (bus.req == 2'b11) ? (ptr ? 2'b01 : 2'b10) : fixed_pri(bus.req);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                 ptr <= 1'b0;
        else if (state == S_IDLE && bus.req != '0) ptr <= win[1];
    end
`else
    always_comb win = fixed_pri(bus.req);
`endif

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .expire   (expire)
    );

    always_comb begin
        state_nxt      = state;
        gnt_nxt        = gnt;
        ack_nxt        = 2'b00;
        aborted_nxt    = 1'b0;
        abort_seen_nxt = abort_seen;
        load           = 1'b0;
        load_val       = '0;
        case (state)
            S_IDLE: begin
                abort_seen_nxt = 1'b0;
                if (bus.req != 2'b00) begin
                    gnt_nxt   = win;
                    state_nxt = S_EXTEND;
                    load      = 1'b1;
                    load_val  = CNT_W'(T_EXT - 1);
                end
            end
            S_EXTEND: begin
                // Abort beats a coinciding expiry: the driver must see a STOP before retracting.
                if (bus.abort) begin
                    state_nxt      = S_ABGAP;
                    abort_seen_nxt = 1'b1;
                end else if (expire) begin
                    state_nxt = S_HOLD;
                    load      = 1'b1;
                    load_val  = CNT_W'(T_HOLD - 1);
                end
            end
            S_HOLD: begin
                if (bus.abort || expire) begin
                    state_nxt = S_RETRACT;
                    load      = 1'b1;
                    load_val  = CNT_W'(T_RET - 1);
                    if (bus.abort) abort_seen_nxt = 1'b1;
                end
            end
            S_ABGAP: begin
                state_nxt = S_RETRACT;
                load      = 1'b1;
                load_val  = CNT_W'(T_RET - 1);
            end
            S_RETRACT: begin
                if (expire) begin
                    state_nxt   = S_DONE;
                    ack_nxt     = gnt;
                    aborted_nxt = abort_seen;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
                gnt_nxt   = 2'b00;
            end
            default: begin
                state_nxt = S_IDLE;
                gnt_nxt   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            gnt        <= 2'b00;
            ack        <= 2'b00;
            aborted    <= 1'b0;
            abort_seen <= 1'b0;
            busy       <= 1'b0;
            command    <= CMD_STOP;
        end else begin
            state      <= state_nxt;
            gnt        <= gnt_nxt;
            ack        <= ack_nxt;
            aborted    <= aborted_nxt;
            abort_seen <= abort_seen_nxt;
            busy       <= (state_nxt != S_IDLE);
            command    <= state_cmd(state_nxt);
        end
    end

    assign bus.gnt     = gnt;
    assign bus.ack     = ack;
    assign bus.aborted = aborted;
    assign bus.busy    = busy;
    assign bus.command = command;

endmodule

// File: tb/tb_panel_sequencer.sv
// Bench for panel_sequencer with short phases (extend 5, hold 3, retract 4).
// Expected per-cycle command traces are built from phase lengths and abort position.
module tb_panel_sequencer;

    localparam int TE = 5;
    localparam int TH = 3;
    localparam int TR = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   last_owner = 0;

    panel_sequencer_if bus ();

    panel_sequencer #(.T_EXT(TE), .T_HOLD(TH), .T_RET(TR), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [1:0] model_owner(logic [1:0] r);
`ifdef PANEL_SEQ_ROUND_ROBIN_EN
        if (r == 2'b11) return (last_owner == 0) ? 2'b10 : 2'b01;
`endif
        return r[0] ? 2'b01 : 2'b10;
    endfunction

    // Call at a negedge with the DUT idle. ab_ph: 0 none, 1 extend, 2 hold, 3 retract; ab_k: 1-based cycle in that phase.
    task automatic run_seq(input logic [1:0] r_start, input logic [1:0] r_during,
                           input logic [1:0] r_after, input int ab_ph, input int ab_k);
        logic [1:0] exp_cmd[$];
        logic [1:0] owner;
        int         ab_idx;
        logic       exp_ab;
        int         len;
        bit         last;
        owner      = model_owner(r_start);
        last_owner = owner[1] ? 1 : 0;
        ab_idx     = -1;
        exp_ab     = 1'b0;
        if (ab_ph == 1) begin
            ab_idx = ab_k - 1;
            exp_ab = 1'b1;
            repeat (ab_k) exp_cmd.push_back(2'b01);
            exp_cmd.push_back(2'b00);
        end else if (ab_ph == 2) begin
            ab_idx = TE + ab_k - 1;
            exp_ab = 1'b1;
            repeat (TE) exp_cmd.push_back(2'b01);
            repeat (ab_k) exp_cmd.push_back(2'b00);
        end else begin
            if (ab_ph == 3) ab_idx = TE + TH + ab_k - 1;
            repeat (TE) exp_cmd.push_back(2'b01);
            repeat (TH) exp_cmd.push_back(2'b00);
        end
        repeat (TR) exp_cmd.push_back(2'b10);
        exp_cmd.push_back(2'b00);
        len = exp_cmd.size();

        bus.req   = r_start;
        bus.abort = 1'b0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            last = (i == len - 1);
            n_tests++;
            if (bus.command !== exp_cmd[i]) begin
                n_fail++;
                $display("FAIL seq_command cycle %0d: got %b expected %b", i, bus.command, exp_cmd[i]);
            end
            n_tests++;
            if (bus.busy !== 1'b1) begin
                n_fail++;
                $display("FAIL seq_busy cycle %0d: got %b expected 1", i, bus.busy);
            end
            if (!last) begin
                n_tests++;
                if (bus.gnt !== owner) begin
                    n_fail++;
                    $display("FAIL seq_gnt cycle %0d: got %b expected %b", i, bus.gnt, owner);
                end
            end
            n_tests++;
            if (bus.ack !== (last ? owner : 2'b00)) begin
                n_fail++;
                $display("FAIL seq_ack cycle %0d: got %b expected %b", i, bus.ack, last ? owner : 2'b00);
            end
            n_tests++;
            if (bus.aborted !== (last ? exp_ab : 1'b0)) begin
                n_fail++;
                $display("FAIL seq_aborted cycle %0d: got %b expected %b", i, bus.aborted, last ? exp_ab : 1'b0);
            end
            bus.req   = last ? r_after : r_during;
            bus.abort = (i == ab_idx);
        end
        @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0 || bus.gnt !== 2'b00 || bus.command !== 2'b00 || bus.ack !== 2'b00) begin
            n_fail++;
            $display("FAIL seq_idle_gap: busy=%b gnt=%b command=%b ack=%b expected 0/00/00/00",
                     bus.busy, bus.gnt, bus.command, bus.ack);
        end
        bus.req   = 2'b00;
        bus.abort = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        bus.req   = 2'b00;
        bus.abort = 1'b0;
        #1;
        n_tests++;
        if (bus.command !== 2'b00 || bus.gnt !== 2'b00 || bus.ack !== 2'b00 ||
            bus.aborted !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: command=%b gnt=%b ack=%b aborted=%b busy=%b expected all zero",
                     bus.command, bus.gnt, bus.ack, bus.aborted, bus.busy);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (bus.busy !== 1'b0 || bus.command !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_no_req: busy=%b command=%b expected 0/00", bus.busy, bus.command);
        end
    endtask

    task automatic test_single();
        run_seq(2'b01, 2'b00, 2'b00, 0, 0);
        run_seq(2'b10, 2'b10, 2'b00, 0, 0);
    endtask

    task automatic test_fixed_priority();
        run_seq(2'b11, 2'b11, 2'b11, 0, 0);
        run_seq(2'b11, 2'b11, 2'b10, 0, 0);
        run_seq(2'b10, 2'b10, 2'b00, 0, 0);
    endtask

    task automatic test_abort();
        run_seq(2'b01, 2'b01, 2'b00, 1, 2);
        run_seq(2'b01, 2'b00, 2'b00, 1, 1);
        run_seq(2'b10, 2'b00, 2'b00, 1, TE);
        run_seq(2'b01, 2'b00, 2'b00, 2, 1);
        run_seq(2'b01, 2'b00, 2'b00, 2, TH);
        run_seq(2'b10, 2'b00, 2'b00, 3, 2);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 16; n++) begin
            int ph;
            int k;
            ph = int'($urandom_range(0, 3));
            case (ph)
                1:       k = int'($urandom_range(1, TE));
                2:       k = int'($urandom_range(1, TH));
                3:       k = int'($urandom_range(1, TR));
                default: k = 0;
            endcase
            run_seq(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), ph, k);
        end
    endtask

    task automatic test_reset_mid();
        bus.req = 2'b01;
        @(negedge clk);
        bus.req = 2'b00;
        repeat (TE + 1) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if (bus.command !== 2'b00 || bus.gnt !== 2'b00 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_hold: command=%b gnt=%b busy=%b expected 00/00/0",
                     bus.command, bus.gnt, bus.busy);
        end
        last_owner = 0;
        repeat (2) begin
            @(negedge clk);
            n_tests++;
            if (bus.ack !== 2'b00 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_no_ack: ack=%b busy=%b expected 00/0", bus.ack, bus.busy);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        run_seq(2'b01, 2'b00, 2'b00, 0, 0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_fixed_priority();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
